// File: rtl/adder_pkg.sv
// Shared types and widths for the multi-precision add sequencer.
package adder_pkg;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Slice index width; at least one bit so WORDS=1 still has a legal vector.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction
endpackage

// File: rtl/adder_16bit_csa.sv
// 16-bit carry-select adder: the low byte ripples, and the high byte is precomputed for both carries.
module adder_16bit_csa (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [8:0] w_lo, w_hi0, w_hi1;

  assign w_lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
  assign w_hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign w_hi1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

  assign sum  = {(w_lo[8] ? w_hi1[7:0] : w_hi0[7:0]), w_lo[7:0]};
  assign cout = w_lo[8] ? w_hi1[8] : w_hi0[8];
endmodule

// File: rtl/adder_mp_seq.sv
// WORDS x 16-bit add sequencer. It reuses one 16-bit adder, LSW first, with the carry held in a register.
// Optional ADDER_MP_SEQ_SUB_EN adds in_sub, which gives A-B-in_cin (out_cout=1 means no borrow).
module adder_mp_seq
  import adder_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*WORD_W-1:0] in_a,
  input  logic [WORDS*WORD_W-1:0] in_b,
  input  logic                    in_cin,
`ifdef ADDER_MP_SEQ_SUB_EN
  input  logic                    in_sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORDS*WORD_W-1:0] out_sum,
  output logic                    out_cout,
  output logic                    busy
);
  localparam int            IW   = idx_w(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t                         r_state;
  logic [WORDS-1:0][WORD_W-1:0]   r_a, r_b, r_sum;
  logic [IW-1:0]                  r_idx;
  logic                           r_carry, r_cout, r_valid, r_busy, r_sub;
  logic [WORD_W-1:0]              w_sa, w_sb, w_s;
  logic                           w_co, w_sub_in;

`ifdef ADDER_MP_SEQ_SUB_EN
  assign w_sub_in = in_sub;
`else
  assign w_sub_in = 1'b0;
`endif

  // Subtraction is A + ~B + ~cin, so only the B slice and the seed carry change.
  assign w_sa = r_a[r_idx];
  assign w_sb = r_b[r_idx] ^ {WORD_W{r_sub}};

  adder_16bit_csa u_csa (
    .a    (w_sa),
    .b    (w_sb),
    .cin  (r_carry),
    .sum  (w_s),
    .cout (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_sub   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= in_a;
          r_b     <= in_b;
          r_sub   <= w_sub_in;
          r_carry <= in_cin ^ w_sub_in;
          r_idx   <= '0;
          r_busy  <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          r_sum[r_idx] <= w_s;
          r_carry      <= w_co;
          if (r_idx == LAST) begin
            r_cout  <= w_co;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        DONE: if (out_ready) begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_valid;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign busy      = r_busy;
endmodule

// File: tb/tb_adder_mp_seq.sv
// Scoreboard bench for adder_mp_seq at WORDS=4 and WORDS=1. It also covers subtraction when ADDER_MP_SEQ_SUB_EN is defined.
module tb_adder_mp_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv4, ir4, ic4, ov4, or4, oc4, bz4, sub4;
  logic [63:0] a4, b4, s4;
  logic        iv1, ir1, ic1, ov1, or1, oc1, bz1, sub1;
  logic [15:0] a1, b1, s1;

  int checks   = 0;
  int failures = 0;
  logic [64:0] q4[$];
  logic [16:0] q1[$];

  adder_mp_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4), .in_cin(ic4),
`ifdef ADDER_MP_SEQ_SUB_EN
    .in_sub(sub4),
`endif
    .out_valid(ov4), .out_ready(or4), .out_sum(s4), .out_cout(oc4), .busy(bz4));

  adder_mp_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_a(a1), .in_b(b1), .in_cin(ic1),
`ifdef ADDER_MP_SEQ_SUB_EN
    .in_sub(sub1),
`endif
    .out_valid(ov1), .out_ready(or1), .out_sum(s1), .out_cout(oc1), .busy(bz1));

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] model4(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
    logic [64:0] r;
    if (s) begin
      r[63:0] = a - b - {63'd0, c};
      r[64]   = ({1'b0, a} >= ({1'b0, b} + {64'd0, c}));
    end else begin
      r = {1'b0, a} + {1'b0, b} + {64'd0, c};
    end
    return r;
  endfunction

  function automatic logic [16:0] model1(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    logic [16:0] r;
    if (s) begin
      r[15:0] = a - b - {15'd0, c};
      r[16]   = ({1'b0, a} >= ({1'b0, b} + {16'd0, c}));
    end else begin
      r = {1'b0, a} + {1'b0, b} + {16'd0, c};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op4(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s,
                     input int gap, input string tag);
    int n;
    n = 0;
    while (!ir4 && n < 50) begin tick(); n++; end
    chk({tag, "_inrdy"}, 65'(ir4), 65'd1);
    a4 = a; b4 = b; ic4 = c; sub4 = s; iv4 = 1'b1;
    q4.push_back(model4(a, b, c, s));
    tick();
    iv4 = 1'b0; a4 = ~a; b4 = ~b; ic4 = ~c; sub4 = ~s;
    if (gap == 0) or4 = 1'b1;
    n = 0;
    while (!ov4 && n < 50) begin tick(); n++; end
    chk({tag, "_lat"}, 65'(n), 65'd4);
    repeat (gap) tick();
    or4 = 1'b1;
    chk({tag, "_res"}, {oc4, s4}, q4.pop_front());
    tick();
    or4 = 1'b0;
    chk({tag, "_idle"}, {63'd0, ov4, ir4}, 65'd1);
  endtask

  task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                     input int gap, input string tag);
    int n;
    n = 0;
    while (!ir1 && n < 50) begin tick(); n++; end
    a1 = a; b1 = b; ic1 = c; sub1 = s; iv1 = 1'b1;
    q1.push_back(model1(a, b, c, s));
    tick();
    iv1 = 1'b0; a1 = ~a; b1 = ~b; ic1 = ~c; sub1 = ~s;
    if (gap == 0) or1 = 1'b1;
    n = 0;
    while (!ov1 && n < 50) begin tick(); n++; end
    chk({tag, "_lat"}, 65'(n), 65'd1);
    repeat (gap) tick();
    or1 = 1'b1;
    chk({tag, "_res"}, {48'd0, oc1, s1}, {48'd0, q1.pop_front()});
    tick();
    or1 = 1'b0;
  endtask

  initial begin
    logic [63:0] hold;
    logic        rs;
    int          n;
    rst_n = 1'b0;
    iv4 = 0; ic4 = 0; or4 = 0; sub4 = 0; a4 = '0; b4 = '0;
    iv1 = 0; ic1 = 0; or1 = 0; sub1 = 0; a1 = '0; b1 = '0;
    #12;
    chk("rst_state", {59'd0, ir4, ov4, oc4, bz4, ir1, ov1}, {59'd0, 6'b100010});
    chk("rst_sum", {1'b0, s4}, 65'd0);
    chk("rst_busy1", 65'(bz1), 65'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, "ripple");
    op4(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0, 2, "slice");

    // Backpressure: a result held in DONE while a new request waits.
    a4 = 64'h1234_5678_9ABC_DEF0; b4 = 64'h1111_1111_1111_1111; ic4 = 0; sub4 = 0; iv4 = 1;
    q4.push_back(model4(a4, b4, 1'b0, 1'b0));
    tick();
    iv4 = 0;
    n = 0;
    while (!ov4 && n < 50) begin tick(); n++; end
    a4 = 64'hDEAD_BEEF_0000_FFFF; b4 = 64'h0000_0000_0001_0001; ic4 = 1; iv4 = 1; or4 = 0;
    hold = s4;
    repeat (6) begin
      tick();
      chk("bp_inrdy", 65'(ir4), 65'd0);
      chk("bp_stable", {1'b0, s4}, {1'b0, hold});
    end
    chk("bp_res", {oc4, s4}, q4.pop_front());
    or4 = 1;
    tick();
    chk("bp_idle", {63'd0, ov4, ir4}, 65'd1);
    q4.push_back(model4(a4, b4, 1'b1, 1'b0));
    or4 = 0;
    tick();
    iv4 = 0; a4 = '0; b4 = '0;
    n = 0;
    while (!ov4 && n < 50) begin tick(); n++; end
    chk("bp_lat", 65'(n), 65'd4);
    chk("bp_res2", {oc4, s4}, q4.pop_front());
    or4 = 1;
    tick();
    or4 = 0;

    // Reset while RUN is on slice 2.
    a4 = 64'hFFFF_FFFF_FFFF_FFFF; b4 = 64'hFFFF_FFFF_FFFF_FFFF; iv4 = 1;
    tick();
    iv4 = 0;
    tick();
    tick();
    chk("mid_busy", 65'(bz4), 65'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {62'd0, ov4, ir4, bz4}, 65'b010);
    chk("mid_sum", {oc4, s4}, 65'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    op4(64'd3, 64'd4, 1'b0, 1'b0, 0, "post_rst");

`ifdef ADDER_MP_SEQ_SUB_EN
    op4(64'd5, 64'd7, 1'b0, 1'b1, 0, "sub_neg");
    chk("sub_neg_model", q4.size(), 65'd0);
    op4(64'd7, 64'd5, 1'b0, 1'b1, 1, "sub_pos");
`endif

    for (int i = 0; i < 100; i++) begin
      rs = 1'b0;
`ifdef ADDER_MP_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      op4({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), rs,
          int'($urandom_range(0, 3)), "rnd4");
    end

    for (int i = 0; i < 100; i++) begin
      rs = 1'b0;
`ifdef ADDER_MP_SEQ_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      op1(16'($urandom()), 16'($urandom()), 1'($urandom_range(0, 1)), rs,
          int'($urandom_range(0, 3)), "rnd1");
    end
    op1(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, "w1_wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
